ook_demod: RTL and testbench

OOK receive-side slicer and byte deframer: the other end of the DDS OOK link. It takes 8-bit ADC samples of an OOK carrier, where a mark is carrier present and a space is flat midscale 128 (the DDS output when `freq1 == 0` and `rf_data == 0`). It slices each bit period by average envelope, and recovers UART-style frames: one start mark, 8 data bits LSB first, one stop space. It sits between the ADC capture logic and the byte consumer.

---
 rtl/ook_demod.sv | 168 ++++++++++++++++
 tb/tb_ook_demod.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ook_demod.sv
// ook_demod -- OOK receive slicer and UART-style byte deframer.
//
// Takes 8-bit ADC samples of an on/off-keyed carrier (space = flat midscale
// 128), averages the envelope magnitude over fixed windows of SPB accepted
// samples, slices each window into a bit, and recovers frames made of one
// start mark, 8 data bits (LSB first) and one stop space.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   adc[7:0]    unsigned sample, midscale 128
//   sample_en   adc qualifier; only cycles with sample_en = 1 are counted
//   data_out    last correctly framed byte (holds between frames)
//   data_valid  one-cycle pulse when data_out updates
//   frame_err   one-cycle pulse when the stop window reads as a mark
//   busy        high whenever a frame is in progress
//   state_dbg   current FSM state (IDLE=0, START=1, DATA=2, STOP=3)
//
// Input handshake: sample_en is a pure valid strobe with no ready; the block
// consumes every qualified sample in the cycle it is presented and holds all
// internal state on cycles where sample_en = 0.

module ook_demod #(
    parameter int SPB    = 16,
    parameter int THRESH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] adc,
    input  logic       sample_en,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy,
    output logic [1:0] state_dbg
);

    localparam int ACC_W = 8 + $clog2(SPB) + 1;
    localparam int CNT_W = $clog2(SPB + 1);

    // A window decides 1 when its mean magnitude reaches THRESH, i.e. when
    // the window sum reaches THRESH*SPB (equality counts as a mark).
    localparam logic [ACC_W-1:0] DEC_LEVEL = ACC_W'(THRESH * SPB);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SPB - 1);
    localparam logic [7:0]       TRIG_MAG  = 8'(THRESH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             frame_err_q, frame_err_d;

    logic [7:0]       mag;
    logic [ACC_W-1:0] sum;
    logic             win_end;
    logic             win_bit;

    // Distance from midscale; 128 - 0 = 128 still fits in 8 bits.
    always_comb begin
        mag = (adc >= 8'd128) ? (adc - 8'd128) : (8'd128 - adc);
    end

    // cnt_q holds the number of samples already folded into acc_q, so the
    // SPB-th sample of a window arrives while cnt_q == SPB-1.
    always_comb begin
        sum     = acc_q + {{(ACC_W-8){1'b0}}, mag};
        win_end = (cnt_q == LAST_CNT);
        win_bit = (sum >= DEC_LEVEL);
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        if (sample_en) begin
            if (state_q == S_IDLE) begin
                // The trigger sample is the first sample of the start window.
                if (mag >= TRIG_MAG) begin
                    state_d = S_START;
                    acc_d   = {{(ACC_W-8){1'b0}}, mag};
                    cnt_d   = CNT_W'(1);
                end
            end else if (!win_end) begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                // Window closes on this sample; the next one starts a new window.
                acc_d = '0;
                cnt_d = '0;
                case (state_q)
                    S_START: begin
                        if (win_bit) begin
                            state_d   = S_DATA;
                            bit_idx_d = 3'd0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                    S_DATA: begin
                        // LSB arrives first, so shifting right leaves bit 0 at the bottom.
                        shift_d   = {win_bit, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_d = S_STOP;
                        end
                    end
                    S_STOP: begin
                        if (win_bit) begin
                            frame_err_d = 1'b1;
                        end else begin
                            data_out_d   = shift_q;
                            data_valid_d = 1'b1;
                        end
                        state_d = S_IDLE;
                    end
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        data_out   = data_out_q;
        data_valid = data_valid_q;
        frame_err  = frame_err_q;
        busy       = (state_q != S_IDLE);
        state_dbg  = state_q;
    end

endmodule

// File: tb/tb_ook_demod.sv
// tb_ook_demod -- self-checking bench for ook_demod (SPB = 16, THRESH = 32).
//
// A frame-level model collects the magnitudes of accepted samples since the
// trigger, slices them into SPB-sized windows and derives the expected
// outputs; a compare process checks every DUT output on every negedge. A
// byte scoreboard and a few literal expectations pin the model.

module tb_ook_demod;

    localparam int SPB    = 16;
    localparam int THRESH = 32;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] adc;
    logic       sample_en;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    ook_demod #(.SPB(SPB), .THRESH(THRESH)) dut (
        .clk        (clk),
        .rst        (rst),
        .adc        (adc),
        .sample_en  (sample_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    bit chk_on  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit         m_in_frame = 1'b0;
    int         m_mags[$];
    logic [7:0] exp_data  = 8'h00;
    logic       exp_valid = 1'b0;
    logic       exp_ferr  = 1'b0;
    logic       exp_busy  = 1'b0;

    function automatic int mag_of(input logic [7:0] a);
        int v;
        v = int'(a);
        return (v >= 128) ? v - 128 : 128 - v;
    endfunction

    // Window w (0 = start window) of the current frame reads as a mark when
    // its average magnitude is at least THRESH.
    function automatic bit window_bit(input int w);
        int s;
        s = 0;
        for (int i = 0; i < SPB; i++) s += m_mags[w * SPB + i];
        return (s >= THRESH * SPB);
    endfunction

    task automatic model_step();
        int  m;
        int  k;
        bit  b;
        logic [7:0] byte_v;
        if (rst) begin
            m_in_frame = 1'b0;
            m_mags.delete();
            exp_data  = 8'h00;
            exp_valid = 1'b0;
            exp_ferr  = 1'b0;
        end else begin
            exp_valid = 1'b0;
            exp_ferr  = 1'b0;
            if (sample_en) begin
                m = mag_of(adc);
                if (!m_in_frame) begin
                    if (m >= THRESH) begin
                        m_in_frame = 1'b1;
                        m_mags.delete();
                        m_mags.push_back(m);
                    end
                end else begin
                    m_mags.push_back(m);
                    if (m_mags.size() % SPB == 0) begin
                        k = m_mags.size() / SPB;
                        b = window_bit(k - 1);
                        if (k == 1 && !b) begin
                            m_in_frame = 1'b0;
                        end else if (k == 10) begin
                            m_in_frame = 1'b0;
                            if (b) begin
                                exp_ferr = 1'b1;
                            end else begin
                                for (int j = 0; j < 8; j++) byte_v[j] = window_bit(1 + j);
                                exp_data  = byte_v;
                                exp_valid = 1'b1;
                            end
                        end
                    end
                end
            end
        end
        exp_busy = m_in_frame;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- scoreboard / compare ----------------
    logic [7:0] exp_q[$];
    int valid_cnt = 0;
    int ferr_cnt  = 0;
    int last_valid_cyc = -1;
    int last_ferr_cyc  = -1;

    initial begin
        @(posedge clk);
        chk_on = 1'b1;
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("data_valid", data_valid, exp_valid);
            chk("frame_err", frame_err, exp_ferr);
            chk("busy", busy, exp_busy);
            chk("data_out", data_out, exp_data);
            if (data_valid || frame_err) chk("pulse_exclusive", data_valid & frame_err, 0);
            if (data_valid === 1'b1) begin
                valid_cnt++;
                last_valid_cyc = cyc;
                if (exp_q.size() == 0) chk("sb_unexpected_byte", data_out, 32'hFFFF_FFFF);
                else chk("sb_byte", data_out, exp_q.pop_front());
            end
            if (frame_err === 1'b1) begin
                ferr_cnt++;
                last_ferr_cyc = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    int last_cyc = 0;

    task automatic send_sample(input logic [7:0] v, input bit throttle);
        if (throttle) begin
            while ($urandom_range(0, 1) == 1) begin
                adc       = 8'($urandom);
                sample_en = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        adc       = v;
        sample_en = 1'b1;
        last_cyc  = cyc;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
    endtask

    task automatic send_window(input bit mark, input int mag, input bit throttle);
        for (int i = 0; i < SPB; i++) begin
            if (mark) send_sample((i % 2 == 0) ? 8'(128 + mag) : 8'(128 - mag), throttle);
            else      send_sample(8'd128, throttle);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_mark, input int mag,
                              input bit throttle);
        send_window(1'b1, mag, throttle);
        for (int i = 0; i < 8; i++) send_window(b[i], mag, throttle);
        send_window(stop_mark, mag, throttle);
    endtask

    task automatic send_gap(input int n);
        for (int i = 0; i < n; i++) send_sample(8'd128, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int v0;
        int f0;
        logic [7:0] rb;
        bit  rs;

        // Reset held three cycles with random samples presented.
        rst       = 1'b1;
        sample_en = 1'b1;
        adc       = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            adc = 8'($urandom);
        end
        rst = 1'b0;
        adc = 8'd128;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_pulses", {data_valid, frame_err}, 0);
        send_gap(4);

        // Clean frame 0xA5.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 100, 1'b0);
        send_gap(8);
        chk("clean_valid_count", valid_cnt - v0, 1);
        chk("clean_ferr_count", ferr_cnt - f0, 0);
        chk("clean_data_out", data_out, 8'hA5);
        chk("clean_pulse_cycle", last_valid_cyc, last_cyc - 8 + 1);
        chk("model_pin_a5", exp_data, 8'hA5);

        // Framing error: 0x3C with a mark stop window; data_out keeps 0xA5.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b1, 100, 1'b0);
        send_gap(8);
        chk("ferr_count", ferr_cnt - f0, 1);
        chk("ferr_valid_count", valid_cnt - v0, 0);
        chk("ferr_data_out", data_out, 8'hA5);

        // Glitch: one 200 sample then 15 midscale samples (sum 72 < 512).
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_sample(8'd200, 1'b0);
        @(negedge clk);
        chk("glitch_busy_rise", busy, 1);
        for (int i = 0; i < SPB - 1; i++) send_sample(8'd128, 1'b0);
        @(negedge clk);
        chk("glitch_busy_fall", busy, 0);
        chk("glitch_pulses", (valid_cnt - v0) + (ferr_cnt - f0), 0);

        // Just below the boundary: 160 then 15 x 159 gives 497 < 512.
        send_sample(8'd160, 1'b0);
        for (int i = 0; i < SPB - 1; i++) send_sample(8'd159, 1'b0);
        @(negedge clk);
        chk("below_boundary_idle", busy, 0);
        send_gap(4);

        // Boundary: constant mag 32 windows sum to exactly 512 and read as 1.
        v0 = valid_cnt;
        exp_q.push_back(8'h81);
        for (int i = 0; i < SPB; i++) send_sample(8'd160, 1'b0);
        @(negedge clk);
        chk("boundary_start_accepted", busy, 1);
        for (int w = 0; w < 8; w++) begin
            for (int i = 0; i < SPB; i++) send_sample((w == 0 || w == 7) ? 8'd160 : 8'd128, 1'b0);
        end
        send_gap(SPB + 4);
        chk("boundary_valid_count", valid_cnt - v0, 1);
        chk("boundary_data_out", data_out, 8'h81);

        // Throttled frame 0x5A.
        v0 = valid_cnt;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b0, 100, 1'b1);
        send_gap(6);
        chk("throttle_valid_count", valid_cnt - v0, 1);
        chk("throttle_data_out", data_out, 8'h5A);
        chk("throttle_pulse_cycle", last_valid_cyc, last_cyc - 6 + 1);

        // Reset after five data bits, then a full 0xC3 frame.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_window(1'b1, 100, 1'b0);
        for (int i = 0; i < 5; i++) send_window(((8'hC3 >> i) & 8'h01) != 0, 100, 1'b0);
        rst       = 1'b1;
        sample_en = 1'b1;
        adc       = 8'd228;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        sample_en = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_data_out", data_out, 0);
        send_gap(4);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b0, 100, 1'b0);
        send_gap(6);
        chk("midrst_valid_count", valid_cnt - v0, 1);
        chk("midrst_ferr_count", ferr_cnt - f0, 0);
        chk("midrst_data_out_c3", data_out, 8'hC3);

        // Randomized frames: byte, amplitude, stop polarity and throttling.
        for (int n = 0; n < 6; n++) begin
            rb = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 3) == 0);
            if (!rs) exp_q.push_back(rb);
            send_frame(rb, rs, $urandom_range(40, 127), 1'($urandom_range(0, 1)));
            send_gap($urandom_range(1, 20));
        end
        send_gap(4);

        chk("sb_queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
